dmem_arbiter: RTL and testbench

- Shares the single-port data memory between the ARM core and a secondary board-side requester (debug/display reader feeding the Basys display path).
- The core has priority. An anti-starvation streak counter forces one debug slot after MAX_STREAK consecutive core wins over a waiting debug request; the core is stalled for that cycle.
- Sits between arm/dmem in the top level. Memory timing is unchanged: asynchronous read, write on rising clk.

---
 rtl/dmem_arb_pkg.sv | 19 +
 rtl/arb_streak_ctr.sv | 33 +++
 rtl/dmem_arbiter.sv | 110 +++++++++++
 tb/tb_dmem_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
package dmem_arb_pkg;

    // Which requester owns the memory port this cycle
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_CORE = 2'd1,
        GNT_DBG  = 2'd2
    } gnt_src_e;

    localparam int unsigned DEF_MAX_STREAK = 4;
    localparam int unsigned DEF_CW         = 16;

    // Width needed to hold a streak value 0..max_streak
    function automatic int unsigned streak_width(input int unsigned max_streak);
        return (max_streak < 1) ? 1 : $clog2(max_streak + 1);
    endfunction

endpackage

// File: rtl/arb_streak_ctr.sv
// Saturating count of consecutive core wins over a waiting debug request.
module arb_streak_ctr
    import dmem_arb_pkg::*;
#(
    parameter int unsigned MAX_STREAK = DEF_MAX_STREAK
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_full
);

    localparam int unsigned SW = streak_width(MAX_STREAK);

    logic [SW-1:0] r_cnt;
    logic          w_full;

    assign w_full = (r_cnt == SW'(MAX_STREAK));
    assign o_full = w_full;

    // Clear has priority; increment stops at MAX_STREAK
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !w_full) begin
            r_cnt <= r_cnt + SW'(1);
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the core and a debug reader.
// Core has priority; a streak limit forces one debug slot (core stalled).
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned MAX_STREAK = DEF_MAX_STREAK,
    parameter int unsigned CW         = DEF_CW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic [DW-1:0] c_rdata,
    output logic          c_stall,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    output logic [CW-1:0] stall_cnt
);

    gnt_src_e      w_gnt_src;
    logic          w_gnt_d;
    logic          w_gnt_c;
    logic          w_d_busy;
    logic          w_streak_full;
    logic          r_d_ack;
    logic [DW-1:0] r_d_rdata;
    logic [CW-1:0] r_stall_cnt;

    // The ack cycle doubles as the busy cycle: a held d_req is not regranted
    assign w_d_busy = r_d_ack;

    arb_streak_ctr #(
        .MAX_STREAK (MAX_STREAK)
    ) u_streak (
        .clk    (clk),
        .rst_n  (reset),
        .i_clr  (w_gnt_d | ~d_req),
        .i_inc  (w_gnt_c & d_req & ~w_d_busy),
        .o_full (w_streak_full)
    );

    // Grant: debug only when core idle or the streak limit is reached
    always_comb begin
        w_gnt_src = GNT_NONE;
        if (d_req && !w_d_busy && (!c_req || w_streak_full)) begin
            w_gnt_src = GNT_DBG;
        end else if (c_req) begin
            w_gnt_src = GNT_CORE;
        end
    end

    assign w_gnt_d = (w_gnt_src == GNT_DBG);
    assign w_gnt_c = (w_gnt_src == GNT_CORE);

    // Memory port mux; write enable only with a grant and never in reset
    always_comb begin
        m_addr  = c_addr;
        m_wdata = c_wdata;
        m_we    = w_gnt_c & c_we;
        if (w_gnt_d) begin
            m_addr  = d_addr;
            m_wdata = d_wdata;
            m_we    = d_we;
        end
        if (!reset) begin
            m_we = 1'b0;
        end
    end

    assign c_rdata   = m_rdata;
    assign c_stall   = c_req & w_gnt_d;
    assign d_ack     = r_d_ack;
    assign d_rdata   = r_d_rdata;
    assign stall_cnt = r_stall_cnt;

    // Debug return path: ack pulse and captured read data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_d_ack   <= 1'b0;
            r_d_rdata <= '0;
        end else begin
            r_d_ack <= w_gnt_d;
            if (w_gnt_d && !d_we) begin
                r_d_rdata <= m_rdata;
            end
        end
    end

    // Saturating count of core stall cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (c_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural memory and model.
module tb_dmem_arbiter;

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned MS    = 4;
    localparam int unsigned CW    = 4;
    localparam int          SATV  = 15;

    logic          clk;
    logic          reset;
    logic          c_req, c_we, d_req, d_we;
    logic [AW-1:0] c_addr, d_addr;
    logic [DW-1:0] c_wdata, d_wdata;
    logic [DW-1:0] c_rdata, d_rdata, m_rdata, m_wdata;
    logic          c_stall, d_ack, m_we;
    logic [AW-1:0] m_addr;
    logic [CW-1:0] stall_cnt;

    int checks   = 0;
    int failures = 0;

    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_STREAK(MS), .CW(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .c_req     (c_req),
        .c_we      (c_we),
        .c_addr    (c_addr),
        .c_wdata   (c_wdata),
        .c_rdata   (c_rdata),
        .c_stall   (c_stall),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .m_we      (m_we),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_rdata   (m_rdata),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    // Environment memory: async read, write on rising edge
    logic [31:0] mem [0:255];
    logic        mem_init_done = 1'b0;
    assign m_rdata = mem[m_addr[9:2]];
    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
            mem_init_done <= 1'b1;
        end else if (m_we) begin
            mem[m_addr[9:2]] <= m_wdata;
        end
    end

    // Reference model state
    logic [31:0] ref_mem [0:255];
    int          md_streak;
    bit          md_busy, md_ack;
    logic [31:0] md_rdata;
    int          md_scnt;
    bit          e_dbg, e_core, e_stall, e_we;
    logic [31:0] e_addr, e_wdata;

    task automatic model_reset();
        md_streak = 0; md_busy = 0; md_ack = 0; md_rdata = '0; md_scnt = 0;
    endtask

    // Who gets memory this cycle, from the arbitration rules
    task automatic model_predict();
        e_dbg   = d_req && !md_busy && (!c_req || md_streak == MS);
        e_core  = c_req && !e_dbg;
        e_stall = c_req && e_dbg;
        e_we    = e_dbg ? d_we : (e_core && c_we);
        e_addr  = e_dbg ? d_addr : c_addr;
        e_wdata = e_dbg ? d_wdata : c_wdata;
    endtask

    // State after the clock edge
    task automatic model_advance();
        bit was_busy;
        was_busy = md_busy;
        if (e_dbg && !d_we) md_rdata = ref_mem[d_addr[9:2]];
        if (e_we) ref_mem[e_addr[9:2]] = e_wdata;
        md_ack  = e_dbg;
        md_busy = e_dbg;
        if (e_dbg || !d_req) md_streak = 0;
        else if (e_core && !was_busy && md_streak < MS) md_streak++;
        if (e_stall && md_scnt < SATV) md_scnt++;
    endtask

    task automatic settle();
        @(negedge clk);
        model_predict();
    endtask

    task automatic next_cycle();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    endtask

    task automatic do_reset();
        drive_idle();
        reset = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 0;
        drive_idle();
        c_req = 1; c_we = 1; c_addr = 32'h10; c_wdata = 32'h77;
        @(negedge clk);
        checks++; if (m_we !== 1'b0) begin failures++; $display("FAIL reset_m_we got=%b exp=0", m_we); end
        checks++; if (m_addr !== 32'h10) begin failures++; $display("FAIL reset_m_addr got=%h exp=10", m_addr); end
        checks++; if (d_ack !== 1'b0) begin failures++; $display("FAIL reset_d_ack got=%b exp=0", d_ack); end
        checks++; if (d_rdata !== 32'h0) begin failures++; $display("FAIL reset_d_rdata got=%h exp=0", d_rdata); end
        checks++; if (stall_cnt !== 4'h0) begin failures++; $display("FAIL reset_stall_cnt got=%h exp=0", stall_cnt); end
        checks++; if (c_stall !== 1'b0) begin failures++; $display("FAIL reset_c_stall got=%b exp=0", c_stall); end
        do_reset();
    endtask

    task automatic test_core_only();
        logic [31:0] a;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            a = 32'h40 + 32'(4 * i);
            c_req = 1; c_we = 1; c_addr = a; c_wdata = a + 1;
            settle();
            checks++; if (m_we !== 1'b1 || m_addr !== a || m_wdata !== a + 1)
                begin failures++; $display("FAIL core_store got=%b/%h/%h exp=1/%h/%h", m_we, m_addr, m_wdata, a, a + 1); end
            checks++; if (c_stall !== 1'b0) begin failures++; $display("FAIL core_store_stall got=%b exp=0", c_stall); end
            next_cycle();
        end
        for (int i = 0; i < 10; i++) begin
            a = 32'h40 + 32'(4 * i);
            c_req = 1; c_we = 0; c_addr = a;
            settle();
            checks++; if (c_rdata !== a + 1) begin failures++; $display("FAIL core_load got=%h exp=%h", c_rdata, a + 1); end
            checks++; if (m_we !== 1'b0) begin failures++; $display("FAIL core_load_we got=%b exp=0", m_we); end
            next_cycle();
        end
        settle();
        checks++; if (stall_cnt !== 4'h0) begin failures++; $display("FAIL core_stall_cnt got=%h exp=0", stall_cnt); end
        next_cycle();
    endtask

    task automatic test_debug_only();
        drive_idle();
        d_req = 1; d_we = 0; d_addr = 32'h50; c_addr = 32'h60;
        settle();
        checks++; if (m_addr !== 32'h50 || m_we !== 1'b0 || c_stall !== 1'b0 || d_ack !== 1'b0)
            begin failures++; $display("FAIL dbg_grant got=%h/%b/%b/%b exp=50/0/0/0", m_addr, m_we, c_stall, d_ack); end
        next_cycle();
        d_addr = 32'h54;
        settle();
        checks++; if (d_ack !== 1'b1 || d_rdata !== 32'h51)
            begin failures++; $display("FAIL dbg_ack got=%b/%h exp=1/51", d_ack, d_rdata); end
        checks++; if (m_addr !== 32'h60) begin failures++; $display("FAIL dbg_busy_regrant got=%h exp=60", m_addr); end
        next_cycle();
        settle();
        checks++; if (m_addr !== 32'h54 || d_ack !== 1'b0)
            begin failures++; $display("FAIL dbg_new_grant got=%h/%b exp=54/0", m_addr, d_ack); end
        next_cycle();
        d_req = 0;
        settle();
        checks++; if (d_ack !== 1'b1 || d_rdata !== 32'h55)
            begin failures++; $display("FAIL dbg_ack2 got=%b/%h exp=1/55", d_ack, d_rdata); end
        next_cycle();
        settle();
        checks++; if (d_ack !== 1'b0) begin failures++; $display("FAIL dbg_ack_pulse got=%b exp=0", d_ack); end
        next_cycle();
    endtask

    // Held contention: debug slot at cycle 4, then every 6 (ack cycle + 4 core + debug)
    task automatic test_contention();
        int  n_d;
        bit  exp_d, exp_ack;
        do_reset();
        c_req = 1; c_we = 0; c_addr = 32'h40;
        d_req = 1; d_we = 0; d_addr = 32'h44;
        n_d = 0;
        for (int i = 0; i <= 16; i++) begin
            exp_d   = (i >= 4) && ((i - 4) % 6 == 0);
            exp_ack = (i >= 5) && ((i - 5) % 6 == 0);
            settle();
            checks++; if (c_stall !== exp_d) begin failures++; $display("FAIL cont_stall cyc=%0d got=%b exp=%b", i, c_stall, exp_d); end
            checks++; if (m_addr !== (exp_d ? 32'h44 : 32'h40)) begin failures++; $display("FAIL cont_addr cyc=%0d got=%h", i, m_addr); end
            checks++; if (d_ack !== exp_ack) begin failures++; $display("FAIL cont_ack cyc=%0d got=%b exp=%b", i, d_ack, exp_ack); end
            checks++; if (stall_cnt !== CW'(n_d)) begin failures++; $display("FAIL cont_stall_cnt cyc=%0d got=%0d exp=%0d", i, stall_cnt, n_d); end
            if (exp_d) n_d++;
            next_cycle();
        end
        drive_idle();
    endtask

    task automatic test_debug_write();
        logic [31:0] old;
        do_reset();
        old = init_word(32'h80 >> 2);
        c_req = 1; c_we = 0; c_addr = 32'h80; c_wdata = 32'h0BAD_0BAD;
        d_req = 1; d_we = 1; d_addr = 32'h80; d_wdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 8; i++) begin
            if (i == 5) d_req = 0;
            settle();
            checks++; if (c_stall !== (i == 4)) begin failures++; $display("FAIL dwr_stall cyc=%0d got=%b", i, c_stall); end
            checks++; if (m_we !== (i == 4)) begin failures++; $display("FAIL dwr_m_we cyc=%0d got=%b", i, m_we); end
            if (i < 4) begin
                checks++; if (c_rdata !== old) begin failures++; $display("FAIL dwr_old cyc=%0d got=%h exp=%h", i, c_rdata, old); end
            end else if (i > 4) begin
                checks++; if (c_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL dwr_new cyc=%0d got=%h exp=deadbeef", i, c_rdata); end
            end
            next_cycle();
        end
        drive_idle();
    endtask

    task automatic test_async_reset();
        logic [31:0] pat;
        do_reset();
        pat = init_word(32'h88 >> 2);
        d_req = 1; d_we = 1; d_addr = 32'h88; d_wdata = 32'h1234_5678;
        settle();
        checks++; if (m_we !== 1'b1) begin failures++; $display("FAIL areset_pre_we got=%b exp=1", m_we); end
        #2 reset = 0;
        #1;
        checks++; if (m_we !== 1'b0) begin failures++; $display("FAIL areset_m_we got=%b exp=0", m_we); end
        model_reset();
        @(posedge clk);
        #1;
        checks++; if (d_ack !== 1'b0 || d_rdata !== 32'h0 || stall_cnt !== 4'h0)
            begin failures++; $display("FAIL areset_regs got=%b/%h/%h exp=0/0/0", d_ack, d_rdata, stall_cnt); end
        reset = 1;
        c_req = 1; c_we = 0; c_addr = 32'h88;
        d_req = 1; d_we = 0; d_addr = 32'h8C;
        for (int i = 0; i < 6; i++) begin
            settle();
            if (i == 0) begin
                checks++; if (d_ack !== 1'b0) begin failures++; $display("FAIL areset_lost_ack got=%b exp=0", d_ack); end
            end
            checks++; if (c_stall !== (i == 4)) begin failures++; $display("FAIL areset_streak cyc=%0d got=%b", i, c_stall); end
            if (i < 4) begin
                checks++; if (c_rdata !== pat) begin failures++; $display("FAIL areset_nowrite got=%h exp=%h", c_rdata, pat); end
            end
            next_cycle();
        end
        drive_idle();
    endtask

    task automatic test_stall_saturation();
        int n_d;
        bit exp_d;
        do_reset();
        c_req = 1; c_we = 0; c_addr = 32'h40;
        d_req = 1; d_we = 0; d_addr = 32'h44;
        n_d = 0;
        for (int i = 0; i <= 4 + 6 * 19; i++) begin
            exp_d = (i >= 4) && ((i - 4) % 6 == 0);
            settle();
            checks++; if (c_stall !== exp_d) begin failures++; $display("FAIL sat_stall cyc=%0d got=%b exp=%b", i, c_stall, exp_d); end
            if (exp_d) n_d++;
            next_cycle();
        end
        drive_idle();
        settle();
        checks++; if (n_d != 20 || stall_cnt !== 4'd15) begin failures++; $display("FAIL sat_hold got=%0d exp=15 (stalls=%0d)", stall_cnt, n_d); end
        next_cycle();
    endtask

    task automatic test_random();
        bit d_pending;
        do_reset();
        d_pending = 0;
        for (int i = 0; i < 400; i++) begin
            c_req   = ($urandom % 4) != 0;
            c_we    = $urandom % 2;
            c_addr  = 32'h80 + 32'(4 * $urandom_range(0, 15));
            c_wdata = $urandom;
            if (!d_pending || md_ack) begin
                d_pending = 0;
                if ($urandom % 3 == 0) begin
                    d_pending = 1;
                    d_req   = 1;
                    d_we    = $urandom % 2;
                    d_addr  = 32'h80 + 32'(4 * $urandom_range(0, 15));
                    d_wdata = $urandom;
                end else begin
                    d_req = 0;
                end
            end
            settle();
            checks++; if (c_stall !== e_stall || m_we !== e_we || m_addr !== e_addr)
                begin failures++; $display("FAIL rnd_arb cyc=%0d got=%b/%b/%h exp=%b/%b/%h", i, c_stall, m_we, m_addr, e_stall, e_we, e_addr); end
            if (e_we) begin
                checks++; if (m_wdata !== e_wdata) begin failures++; $display("FAIL rnd_wdata cyc=%0d got=%h exp=%h", i, m_wdata, e_wdata); end
            end
            checks++; if (d_ack !== md_ack || d_rdata !== md_rdata)
                begin failures++; $display("FAIL rnd_dbg cyc=%0d got=%b/%h exp=%b/%h", i, d_ack, d_rdata, md_ack, md_rdata); end
            checks++; if (stall_cnt !== CW'(md_scnt)) begin failures++; $display("FAIL rnd_stall_cnt cyc=%0d got=%0d exp=%0d", i, stall_cnt, md_scnt); end
            if (e_core && !c_we) begin
                checks++; if (c_rdata !== ref_mem[c_addr[9:2]])
                    begin failures++; $display("FAIL rnd_core_rd cyc=%0d got=%h exp=%h", i, c_rdata, ref_mem[c_addr[9:2]]); end
            end
            next_cycle();
        end
        drive_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        model_reset();
        test_reset();
        test_core_only();
        test_debug_only();
        test_contention();
        test_debug_write();
        test_async_reset();
        test_stall_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
